alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle control and datapath sequencer that acts as the initiator for the combinational 8-bit ALU.
- Fetches 8-bit instructions over a req/valid handshake and decodes them.
- Reads a 4x8 register file and drives operand1/operand2/alu_op to the ALU.
- Captures result/zero_flag, writes back, keeps a Z flag and handles branch-if-zero. Sits between instruction memory and the ALU in the 8-bit RISC core.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- pc  output  8  current instruction address
- instr_req  output  1  fetch request; high exactly while in FETCH
- instr_valid  input  1  memory response strobe; sampled only in FETCH
- instr_data  input  8  instruction, valid when instr_valid=1
- operand1  output  8  to ALU operand1 (registered)
- operand2  output  8  to ALU operand2 (registered)
- alu_op  output  2  to ALU alu_op (registered)
- alu_result  input  8  from ALU result
- alu_zero  input  1  from ALU zero_flag
- z_flag  output  1  architectural zero flag
- halted  output  1  high in HALT state
- dbg_sel  input  2  register-file debug read select
- dbg_data  output  8  combinational read of R[dbg_sel]

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the clk rising edge; it wins over all other events in that cycle.
- Reset values: state=FETCH, pc=RESET_PC, R0..R3=0, operand1=operand2=0, alu_op=0, z_flag=0, halted=0, instr latch=0.
- Instruction encoding uses instr[7:6] as class:
  - 00 ALU: alu_op=instr[5:4], rd=instr[3:2], rs=instr[1:0]. R[rd] <= R[rd] op R[rs].
  - 01 LDI: rd=instr[5:4]. R[rd] <= {4'b0, instr[3:0]}.
  - 10 BZ: if z_flag=1 then pc <= {2'b00, instr[5:0]}, else pc <= pc+1.
  - 11 SYS: instr[5:0]=0 is HALT; any other value is NOP.
- ALU op meanings (fixed by ALU): 00 AND, 01 OR, 10 XOR, 11 NOT operand1. For NOT, rs is ignored by the ALU but operand2 is still driven with R[rs].
- FETCH:
  - instr_req=1.
  - If instr_valid=1: latch instr_data and go to DECODE.
  - Otherwise stay, with pc held stable for any number of wait cycles.
- DECODE:
  - ALU: operand1<=R[rd], operand2<=R[rs], alu_op<=instr[5:4], go to EXEC.
  - LDI: write R[rd], pc<=pc+1, go to FETCH.
  - BZ: update pc as above, go to FETCH.
  - HALT: go to HALT; pc is not incremented.
  - NOP: pc<=pc+1, go to FETCH.
- EXEC (one cycle, for ALU settling): R[rd]<=alu_result, z_flag<=alu_zero, pc<=pc+1, go to FETCH.
- HALT:
  - halted=1, instr_req=0. Stays until rst; no register, flag or pc change.
- Latency: ALU instruction takes 3 cycles with zero-wait fetch (FETCH, DECODE, EXEC). LDI, BZ and NOP take 2.
- operand1, operand2 and alu_op hold their last values outside EXEC; they change only in the DECODE of an ALU instruction.
- z_flag changes only on ALU writeback. LDI, BZ and NOP leave it unchanged.
- pc arithmetic is modulo 256: 8'hFF+1 wraps to 8'h00. BZ targets are limited to 0..63.
- rd==rs is legal: both operands read the same pre-write value.
- instr_valid outside FETCH is ignored, with no latch and no error.
- Reset during any state (including a FETCH wait or EXEC) aborts the in-flight instruction; no writeback occurs that cycle.
- dbg_data is combinational from the register file and reflects a write on the cycle after it occurs.

Test Plan:
- Reset, then zero-wait fetches of LDI R0,#0xA; LDI R1,#0x6; AND R0,R1 (8'h01) → R0=8'h02, z_flag=0, pc=3. Check alu_op=00, operand1=0x0A and operand2=0x06 during EXEC.
- XOR R2,R2 (8'h2A) after R2 is nonzero → R2=0, z_flag=1. Then BZ 0x30 (8'hB0) → pc=8'h30. Repeat with z_flag=0 → pc increments to the next address.
- NOT R3 (8'h3C) with R3=8'h0F → R3=8'hF0, z_flag=0. Then LDI R3,#0 → z_flag stays 0 (unchanged).
- Hold instr_valid low for 5 cycles in FETCH → instr_req stays 1 and pc is stable. Pulse instr_valid during EXEC → ignored, and no extra instruction executes.
- Run from pc=8'hFF with a NOP → pc wraps to 8'h00. HALT (8'hC0) → halted=1 and instr_req=0 for 10+ cycles, with pc unchanged.
- Assert rst for one cycle mid-EXEC of an OR → R[rd] is not written, all outputs return to reset values, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving an external combinational 8-bit ALU.
// Owns the PC, a 4x8 register file and the architectural Z flag.
module alu_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] pc,
  output logic       instr_req,
  input  logic       instr_valid,
  input  logic [7:0] instr_data,
  output logic [7:0] operand1,
  output logic [7:0] operand2,
  output logic [1:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  output logic       z_flag,
  output logic       halted,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] instr;
  logic [7:0] regs [4];

  logic [1:0] instr_class;
  logic [1:0] alu_rd;
  logic [1:0] alu_rs;
  logic [1:0] ldi_rd;
  logic       sys_is_halt;

  assign instr_class = instr[7:6];
  assign alu_rd      = instr[3:2];
  assign alu_rs      = instr[1:0];
  assign ldi_rd      = instr[5:4];
  assign sys_is_halt = (instr[5:0] == 6'd0);

  assign dbg_data = regs[dbg_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    instr_req = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        case (instr_class)
          2'b00:   state_nx = S_EXEC;
          2'b11:   state_nx = sys_is_halt ? S_HALT : S_FETCH;
          default: state_nx = S_FETCH;
        endcase
      end
      S_EXEC: begin
        state_nx = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nx = S_FETCH;
      end
    endcase
  end

  // Operands are registered at DECODE so the ALU sees stable inputs for all of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr    <= '0;
      operand1 <= '0;
      operand2 <= '0;
      alu_op   <= '0;
      z_flag   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            instr <= instr_data;
          end
        end
        S_DECODE: begin
          case (instr_class)
            2'b00: begin
              operand1 <= regs[alu_rd];
              operand2 <= regs[alu_rs];
              alu_op   <= instr[5:4];
            end
            2'b01: begin
              regs[ldi_rd] <= {4'b0000, instr[3:0]};
              pc           <= pc + 8'd1;
            end
            2'b10: begin
              pc <= z_flag ? {2'b00, instr[5:0]} : pc + 8'd1;
            end
            default: begin
              if (!sys_is_halt) begin
                pc <= pc + 8'd1;
              end
            end
          endcase
        end
        S_EXEC: begin
          regs[alu_rd] <= alu_result;
          z_flag       <= alu_zero;
          pc           <= pc + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a behavioural ALU and instruction driver,
// with hand-computed expected register, flag and pc values.
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] pc;
  logic       instr_req;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [1:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       z_flag;
  logic       halted;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  int total;
  int bad;

  alu_sequencer #(.RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .instr_req  (instr_req),
    .instr_valid(instr_valid),
    .instr_data (instr_data),
    .operand1   (operand1),
    .operand2   (operand2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .z_flag     (z_flag),
    .halted     (halted),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  // External combinational ALU the sequencer drives.
  always_comb begin
    case (alu_op)
      2'b00:   alu_result = operand1 & operand2;
      2'b01:   alu_result = operand1 | operand2;
      2'b10:   alu_result = operand1 ^ operand2;
      default: alu_result = ~operand1;
    endcase
  end
  assign alu_zero = (alu_result == 8'h00);

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%02h expected=%02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
    dbg_sel = idx;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for FETCH; an expired bound shows up as a failed check.
  task automatic wait_fetch(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (instr_req) break;
      step();
    end
    chk(tag, {7'd0, instr_req}, 8'h01);
  endtask

  // Presents one instruction with zero wait; returns 1 time unit into DECODE.
  task automatic issue(input logic [7:0] ins);
    wait_fetch("req_before_issue");
    instr_valid = 1'b1;
    instr_data  = ins;
    step();
    instr_valid = 1'b0;
    instr_data  = 8'h00;
  endtask

  task automatic run(input logic [7:0] ins);
    issue(ins);
    step();
    if (!instr_req) step();
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_data  = 8'h00;
    dbg_sel     = 2'd0;
    step();
    step();
    rst = 1'b0;

    chk("rst_pc", pc, 8'h00);
    chk("rst_req", {7'd0, instr_req}, 8'h01);
    chk("rst_halted", {7'd0, halted}, 8'h00);
    chk("rst_z", {7'd0, z_flag}, 8'h00);
    chk("rst_op1", operand1, 8'h00);
    chk("rst_op2", operand2, 8'h00);
    chk("rst_aluop", {6'd0, alu_op}, 8'h00);
    for (int r = 0; r < 4; r++) chk_reg("rst_reg", r[1:0], 8'h00);

    // LDI R0,#A ; LDI R1,#6 ; AND R0,R1
    run(8'h4A);
    chk_reg("ldi_r0", 2'd0, 8'h0A);
    chk("ldi_pc", pc, 8'h01);
    run(8'h56);
    chk_reg("ldi_r1", 2'd1, 8'h06);
    issue(8'h01);
    chk("and_req_decode", {7'd0, instr_req}, 8'h00);
    step();
    chk("and_exec_aluop", {6'd0, alu_op}, 8'h00);
    chk("and_exec_op1", operand1, 8'h0A);
    chk("and_exec_op2", operand2, 8'h06);
    chk("and_exec_pc", pc, 8'h02);
    step();
    chk_reg("and_r0", 2'd0, 8'h02);
    chk("and_z", {7'd0, z_flag}, 8'h00);
    chk("and_pc", pc, 8'h03);

    // LDI R2,#5 ; XOR R2,R2 -> 0, Z=1 ; BZ 0x30 taken
    run(8'h65);
    run(8'h2A);
    chk_reg("xor_r2", 2'd2, 8'h00);
    chk("xor_z", {7'd0, z_flag}, 8'h01);
    chk("xor_pc", pc, 8'h05);
    run(8'hB0);
    chk("bz_taken_pc", pc, 8'h30);

    // OR R0,R1 -> 06, Z=0 ; BZ 0x30 not taken
    run(8'h11);
    chk_reg("or_r0", 2'd0, 8'h06);
    chk("or_z", {7'd0, z_flag}, 8'h00);
    chk("or_pc", pc, 8'h31);
    run(8'hB0);
    chk("bz_not_taken_pc", pc, 8'h32);

    // LDI R3,#F ; NOT R3 (rs=R0 still driven on operand2)
    run(8'h7F);
    issue(8'h3C);
    step();
    chk("not_exec_aluop", {6'd0, alu_op}, 8'h03);
    chk("not_exec_op1", operand1, 8'h0F);
    chk("not_exec_op2", operand2, 8'h06);
    step();
    chk_reg("not_r3", 2'd3, 8'hF0);
    chk("not_z", {7'd0, z_flag}, 8'h00);
    run(8'h70);
    chk_reg("ldi_r3_zero", 2'd3, 8'h00);
    chk("ldi_keeps_z0", {7'd0, z_flag}, 8'h00);
    chk("ldi_keeps_op1", operand1, 8'h0F);
    run(8'h2A);
    chk("xor_again_z", {7'd0, z_flag}, 8'h01);
    run(8'h60);
    chk("ldi_keeps_z1", {7'd0, z_flag}, 8'h01);
    chk("pc_before_wait", pc, 8'h37);

    // FETCH wait states
    for (int i = 0; i < 5; i++) begin
      chk("wait_req", {7'd0, instr_req}, 8'h01);
      chk("wait_pc", pc, 8'h37);
      step();
    end

    // AND R1,R1 with a stray HALT strobe during EXEC
    issue(8'h05);
    step();
    instr_valid = 1'b1;
    instr_data  = 8'hC0;
    step();
    instr_valid = 1'b0;
    instr_data  = 8'h00;
    chk("stray_req", {7'd0, instr_req}, 8'h01);
    chk("stray_halted", {7'd0, halted}, 8'h00);
    chk("stray_pc", pc, 8'h38);
    chk("and_self_z", {7'd0, z_flag}, 8'h00);
    chk_reg("and_self_r1", 2'd1, 8'h06);
    step();
    chk("stray_idle_req", {7'd0, instr_req}, 8'h01);
    chk("stray_idle_pc", pc, 8'h38);

    // NOPs up to 0xFF, then wrap
    for (int i = 0; i < 199; i++) run(8'hC1);
    chk("nop_pc_ff", pc, 8'hFF);
    run(8'hC1);
    chk("nop_wrap_pc", pc, 8'h00);

    // HALT; strobes while halted must be ignored
    issue(8'hC0);
    step();
    instr_valid = 1'b1;
    instr_data  = 8'h4F;
    for (int i = 0; i < 12; i++) begin
      chk("halt_halted", {7'd0, halted}, 8'h01);
      chk("halt_req", {7'd0, instr_req}, 8'h00);
      chk("halt_pc", pc, 8'h00);
      step();
    end
    instr_valid = 1'b0;
    chk_reg("halt_r0", 2'd0, 8'h06);
    chk("halt_z", {7'd0, z_flag}, 8'h00);

    // Reset out of HALT, then reset mid-EXEC of OR R0,R1
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("halt_rst_halted", {7'd0, halted}, 8'h00);
    run(8'h43);
    run(8'h5C);
    issue(8'h11);
    step();
    chk("or2_exec_op1", operand1, 8'h03);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reg("abort_r0", 2'd0, 8'h00);
    chk_reg("abort_r1", 2'd1, 8'h00);
    chk("abort_pc", pc, 8'h00);
    chk("abort_op1", operand1, 8'h00);
    chk("abort_op2", operand2, 8'h00);
    chk("abort_aluop", {6'd0, alu_op}, 8'h00);
    chk("abort_z", {7'd0, z_flag}, 8'h00);
    chk("abort_halted", {7'd0, halted}, 8'h00);
    chk("abort_req", {7'd0, instr_req}, 8'h01);
    run(8'h69);
    chk_reg("restart_r2", 2'd2, 8'h09);
    chk("restart_pc", pc, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
